// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_ctrl
//  Purpose  : 6502 conditional-branch evaluator and 2/3/4-cycle timing sequencer
//  Revision : 1.0  initial release
// ============================================================================
module branch_ctrl #(
    parameter int N_BIT = 7,
    parameter int V_BIT = 6,
    parameter int Z_BIT = 1,
    parameter int C_BIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [7:0]  status,
    input  logic [7:0]  offset,
    input  logic [15:0] pc_in,
    output logic        busy,
    output logic        done,
    output logic        pc_load,
    output logic        taken,
    output logic        page_cross,
    output logic        illegal,
    output logic [15:0] pc_out,
    output logic [2:0]  cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EVAL  = 3'd1,
        ST_ADDLO = 3'd2,
        ST_FIXHI = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  offset_q, offset_d;
    logic [15:0] pc_in_q, pc_in_d;
    logic [7:0]  lo_q, lo_d;
    logic        carry_q, carry_d;

    logic        taken_q, taken_d;
    logic        page_cross_q, page_cross_d;
    logic        illegal_q, illegal_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [2:0]  cycles_q, cycles_d;

    logic        w_legal;
    logic        w_flag;
    logic        w_cond;
    logic [8:0]  w_sum;
    logic [7:0]  w_hi;

    // Every branch opcode is xxy10000: xx picks the flag, y is the value that takes it.
    assign w_legal = (opcode_q[4:0] == 5'b10000);

    always_comb begin
        w_flag = 1'b0;
        case (opcode_q[7:6])
            2'b00:   w_flag = status_q[N_BIT];
            2'b01:   w_flag = status_q[V_BIT];
            2'b10:   w_flag = status_q[C_BIT];
            default: w_flag = status_q[Z_BIT];
        endcase
    end

    assign w_cond = w_legal && (w_flag == opcode_q[5]);

    // Low-byte add first; the high byte is only fixed up when the page changes.
    assign w_sum  = {1'b0, pc_in_q[7:0]} + {1'b0, offset_q};
    assign w_hi   = pc_in_q[15:8] + {8{offset_q[7]}} + {7'd0, carry_q};

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        status_d     = status_q;
        offset_d     = offset_q;
        pc_in_d      = pc_in_q;
        lo_d         = lo_q;
        carry_d      = carry_q;
        taken_d      = taken_q;
        page_cross_d = page_cross_q;
        illegal_d    = illegal_q;
        pc_out_d     = pc_out_q;
        cycles_d     = cycles_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d     = opcode;
                    status_d     = status;
                    offset_d     = offset;
                    pc_in_d      = pc_in;
                    taken_d      = 1'b0;
                    page_cross_d = 1'b0;
                    illegal_d    = 1'b0;
                    cycles_d     = 3'd0;
                    state_d      = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (w_cond) begin
                    taken_d = 1'b1;
                    state_d = ST_ADDLO;
                end else begin
                    illegal_d = ~w_legal;
                    pc_out_d  = pc_in_q;
                    cycles_d  = 3'd2;
                    state_d   = ST_DONE;
                end
            end
            ST_ADDLO: begin
                lo_d    = w_sum[7:0];
                carry_d = w_sum[8];
                // A carry out with a positive offset, or none with a negative one, changes page.
                if (w_sum[8] ^ offset_q[7]) begin
                    page_cross_d = 1'b1;
                    state_d      = ST_FIXHI;
                end else begin
                    pc_out_d = {pc_in_q[15:8], w_sum[7:0]};
                    cycles_d = 3'd3;
                    state_d  = ST_DONE;
                end
            end
            ST_FIXHI: begin
                pc_out_d = {w_hi, lo_q};
                cycles_d = 3'd4;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            opcode_q     <= 8'h00;
            status_q     <= 8'h00;
            offset_q     <= 8'h00;
            pc_in_q      <= 16'h0000;
            lo_q         <= 8'h00;
            carry_q      <= 1'b0;
            taken_q      <= 1'b0;
            page_cross_q <= 1'b0;
            illegal_q    <= 1'b0;
            pc_out_q     <= 16'h0000;
            cycles_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            status_q     <= status_d;
            offset_q     <= offset_d;
            pc_in_q      <= pc_in_d;
            lo_q         <= lo_d;
            carry_q      <= carry_d;
            taken_q      <= taken_d;
            page_cross_q <= page_cross_d;
            illegal_q    <= illegal_d;
            pc_out_q     <= pc_out_d;
            cycles_q     <= cycles_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign pc_load    = (state_q == ST_DONE) && taken_q;
    assign taken      = taken_q;
    assign page_cross = page_cross_q;
    assign illegal    = illegal_q;
    assign pc_out     = pc_out_q;
    assign cycles     = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_ctrl
//  Purpose  : directed self-checking bench for branch_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  opcode;
    logic [7:0]  status;
    logic [7:0]  offset;
    logic [15:0] pc_in;
    logic        busy;
    logic        done;
    logic        pc_load;
    logic        taken;
    logic        page_cross;
    logic        illegal;
    logic [15:0] pc_out;
    logic [2:0]  cycles;

    int n_checks;
    int n_pass;
    logic [15:0] last_pc;

    branch_ctrl #(
        .N_BIT(7),
        .V_BIT(6),
        .Z_BIT(1),
        .C_BIT(0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .status    (status),
        .offset    (offset),
        .pc_in     (pc_in),
        .busy      (busy),
        .done      (done),
        .pc_load   (pc_load),
        .taken     (taken),
        .page_cross(page_cross),
        .illegal   (illegal),
        .pc_out    (pc_out),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},       {15'd0, busy},       16'h0);
        check({tag, ".done"},       {15'd0, done},       16'h0);
        check({tag, ".pc_load"},    {15'd0, pc_load},    16'h0);
        check({tag, ".taken"},      {15'd0, taken},      16'h0);
        check({tag, ".page_cross"}, {15'd0, page_cross}, 16'h0);
        check({tag, ".illegal"},    {15'd0, illegal},    16'h0);
        check({tag, ".pc_out"},     pc_out,              16'h0000);
        check({tag, ".cycles"},     {13'd0, cycles},     16'h0);
    endtask

    // One branch. After the accepting edge, start is held high with scrambled
    // inputs until done, so a DUT that re-latches or accepts while busy diverges.
    task automatic do_branch(input string tag, input logic [7:0] op, input logic [7:0] st,
                             input logic [7:0] off, input logic [15:0] pc, input int lat,
                             input logic tk, input logic [15:0] exp_pc, input logic pcr,
                             input logic [2:0] cyc, input logic ill);
        int n;
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        status = st;
        offset = off;
        pc_in  = pc;
        @(posedge clk);
        #1;
        opcode = 8'hF0;
        status = ~st;
        offset = ~off;
        pc_in  = ~pc;
        check({tag, ".busy_after_start"}, {15'd0, busy}, 16'h1);
        check({tag, ".taken_cleared"},    {15'd0, taken}, 16'h0);
        check({tag, ".cycles_cleared"},   {13'd0, cycles}, 16'h0);
        check({tag, ".pc_out_held"},      pc_out, last_pc);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, ".done_seen"},  {15'd0, seen}, 16'h1);
        check({tag, ".latency"},    n[15:0], lat[15:0]);
        check({tag, ".pc_load"},    {15'd0, pc_load}, {15'd0, tk});
        check({tag, ".taken"},      {15'd0, taken}, {15'd0, tk});
        check({tag, ".pc_out"},     pc_out, exp_pc);
        check({tag, ".page_cross"}, {15'd0, page_cross}, {15'd0, pcr});
        check({tag, ".cycles"},     {13'd0, cycles}, {13'd0, cyc});
        check({tag, ".illegal"},    {15'd0, illegal}, {15'd0, ill});
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, {15'd0, done}, 16'h0);
        check({tag, ".load_pulse"}, {15'd0, pc_load}, 16'h0);
        check({tag, ".idle"},       {15'd0, busy}, 16'h0);
        check({tag, ".pc_out_hold"}, pc_out, exp_pc);
        check({tag, ".taken_hold"}, {15'd0, taken}, {15'd0, tk});
        last_pc = exp_pc;
    endtask

    initial begin
        int n;
        bit seen;
        n_checks = 0;
        n_pass   = 0;
        last_pc  = 16'h0000;
        reset    = 1'b1;
        start    = 1'b0;
        opcode   = 8'h00;
        status   = 8'h00;
        offset   = 8'h00;
        pc_in    = 16'h0000;
        #1;
        check_all_zero("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        //         tag         op     st     off    pc        lat tk  pc_out    pcr cyc   ill
        do_branch("beq_tk",   8'hF0, 8'h02, 8'h10, 16'h1234, 2, 1, 16'h1244, 0, 3'd2 + 3'd1, 0);
        do_branch("bcc_nt",   8'h90, 8'h01, 8'h40, 16'h2000, 1, 0, 16'h2000, 0, 3'd2, 0);
        do_branch("bmi_x",    8'h30, 8'h80, 8'h20, 16'h12F0, 3, 1, 16'h1310, 1, 3'd4, 0);
        do_branch("bpl_back", 8'h10, 8'h00, 8'hF0, 16'h1005, 3, 1, 16'h0FF5, 1, 3'd4, 0);
        do_branch("nop_ill",  8'hEA, 8'hFF, 8'h05, 16'h4000, 1, 0, 16'h4000, 0, 3'd2, 1);
        do_branch("beq_wrap", 8'hF0, 8'h02, 8'h10, 16'hFFF8, 3, 1, 16'h0008, 1, 3'd4, 0);
        do_branch("bpl_wrap", 8'h10, 8'h00, 8'hFC, 16'h0002, 3, 1, 16'hFFFE, 1, 3'd4, 0);
        do_branch("bne_tk",   8'hD0, 8'h00, 8'hFE, 16'h0300, 3, 1, 16'h02FE, 1, 3'd4, 0);
        do_branch("bne_nt",   8'hD0, 8'h02, 8'h08, 16'h0500, 1, 0, 16'h0500, 0, 3'd2, 0);
        do_branch("bvc_nt",   8'h50, 8'h40, 8'h08, 16'h0600, 1, 0, 16'h0600, 0, 3'd2, 0);
        do_branch("bvs_tk",   8'h70, 8'h40, 8'h7F, 16'h0010, 2, 1, 16'h008F, 0, 3'd3, 0);
        do_branch("bcs_x",    8'hB0, 8'h01, 8'h01, 16'h10FF, 3, 1, 16'h1100, 1, 3'd4, 0);
        do_branch("brk_ill",  8'h00, 8'h00, 8'h10, 16'h0700, 1, 0, 16'h0700, 0, 3'd2, 1);

        // Asynchronous reset landing in FIXHI of a page-crossing branch.
        @(negedge clk);
        start  = 1'b1;
        opcode = 8'h30;
        status = 8'h80;
        offset = 8'h20;
        pc_in  = 16'h12F0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("fixhi.busy",       {15'd0, busy}, 16'h1);
        check("fixhi.page_cross", {15'd0, page_cross}, 16'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_fixhi");
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done || pc_load || busy) seen = 1'b1;
        end
        check("rst_fixhi.no_done", {15'd0, seen}, 16'h0);
        last_pc = 16'h0000;

        do_branch("post_rst", 8'hF0, 8'h02, 8'h10, 16'h1234, 2, 1, 16'h1244, 0, 3'd3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
